rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/rr_arbiter4.sv | 135 +++++++++++++
 tb/tb_rr_arbiter4.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM state encoding and requester sizing.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search over four requesters.
// Scans ptr, ptr+1, ptr+2, ptr+3 and returns the first set bit.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end so the closest hit to ptr is written last
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional hold limit: define ARB_TIMEOUT_EN to force rotation.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] pick_req;
  logic             found;
  logic [IDX_W-1:0] idx;
  logic             grab;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
`endif

  // The owner is masked out so a search while busy only sees others
  always_comb begin
    pick_req = req;
    if (state_q == BUSY) pick_req = req & ~gnt_q;
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (idx)
  );

  // Next-state: new grant, hold, handoff, release or forced rotation
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grab    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) grab = 1'b1;
      end
      BUSY: begin
        if (!req[sel_q]) begin
          if (found) begin
            grab = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LIM) begin
          if (found) begin
            grab  = 1'b1;
            tmo_d = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (grab) begin
      state_d = BUSY;
      gnt_d   = onehot(idx);
      sel_d   = idx;
      ptr_d   = idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  // Arbitration state; reset drops any grant without a handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and the one-cycle forced-release pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4.
// Vector table plus reset and hold-limit sequences.
module tb_rr_arbiter4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t tbl[$];

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{gnt: gnt, sel: sel, busy: busy, timeout: timeout};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b tmo=%b, want gnt=%b sel=%0d busy=%b tmo=%b",
               name, a.gnt, a.sel, a.busy, a.timeout,
               e.gnt, e.sel, e.busy, e.timeout);
    end
  endtask

  // Drive one request vector, expect outputs after the next edge
  task automatic step(input string name, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic b, input logic t);
    exp_t e;
    req = r;
    sb.push_back('{gnt: g, sel: s, busy: b, timeout: t});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_now", '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] s, input logic b);
    tbl.push_back('{req: r, gnt: g, sel: s, busy: b});
  endfunction

  initial begin
    logic [3:0] g;
    logic [1:0] s;
    logic       t;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;

    // idle with no requests
    for (int i = 0; i < 10; i++) add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // full load, each owner drops for one cycle after 3 cycles
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b1110, 4'b0010, 2'd1, 1'b1);
    add(4'b1111, 4'b0010, 2'd1, 1'b1);
    add(4'b1111, 4'b0010, 2'd1, 1'b1);
    add(4'b1101, 4'b0100, 2'd2, 1'b1);
    add(4'b1111, 4'b0100, 2'd2, 1'b1);
    add(4'b1111, 4'b0100, 2'd2, 1'b1);
    add(4'b1011, 4'b1000, 2'd3, 1'b1);
    add(4'b1111, 4'b1000, 2'd3, 1'b1);
    add(4'b1111, 4'b1000, 2'd3, 1'b1);
    add(4'b0111, 4'b0001, 2'd0, 1'b1);
    // release to idle, sel keeps last owner
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // single request, one-cycle latency
    add(4'b0100, 4'b0100, 2'd2, 1'b1);
    add(4'b0010, 4'b0010, 2'd1, 1'b1);
    // owner 1 not preempted, then 3 beats 0
    add(4'b1011, 4'b0010, 2'd1, 1'b1);
    add(4'b1011, 4'b0010, 2'd1, 1'b1);
    add(4'b1011, 4'b0010, 2'd1, 1'b1);
    add(4'b1001, 4'b1000, 2'd3, 1'b1);
    // releasing owner re-requests, waits its turn
    add(4'b0011, 4'b0001, 2'd0, 1'b1);
    add(4'b1011, 4'b0001, 2'd0, 1'b1);
    add(4'b1010, 4'b0010, 2'd1, 1'b1);
    add(4'b1000, 4'b1000, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, 2'd3, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1);

    #2;
    check("reset_hold", '0);
    do_reset();

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].gnt,
           tbl[i].sel, tbl[i].busy, 1'b0);
    end

    // asynchronous reset mid-grant, between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", '0);
    req = 4'b1001;
    @(posedge clk);
    #1;
    check("rst_held", '0);
    rst_n = 1'b1;
    step("post_rst", 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);

    // two requesters held: rotation only with the hold limit
    do_reset();
    for (int i = 0; i < 9; i++) begin
`ifdef ARB_TIMEOUT_EN
      g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      s = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
      t = (i == 4 || i == 8);
`else
      g = 4'b0001;
      s = 2'd0;
      t = 1'b0;
`endif
      step($sformatf("hold2_%0d", i), 4'b0011, g, s, 1'b1, t);
    end

    // lone requester never gets rotated away
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step($sformatf("hold1_%0d", i), 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
